// File: rtl/fpmult_seq_normalize.sv
// Sequential front end of the 8-bit FP multiplier: shift-add significand product,
// normalization, then special-case classification feeding the rounding stage.
module fpmult_seq_normalize #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4,
   parameter int BIAS  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 zeroFlag,
   output logic [MAN_W:0]       RoundM,
   output logic [MAN_W:0]       RoundMP,
   output logic [EXP_W:0]       RoundE,
   output logic [EXP_W:0]       RoundEP,
   output logic                 Sp,
   output logic                 GRS,
   output logic [4:0]           InputExc
);

   localparam int OPW   = EXP_W + MAN_W + 1;
   localparam int SW    = MAN_W + 1;
   localparam int PW    = 2 * SW;
   localparam int EW    = EXP_W + 2;
   localparam int CNT_W = $clog2(MAN_W + 1);
   localparam logic [EW-1:0]    E_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [EXP_W:0]   E_SAT = {1'b0, {EXP_W{1'b1}}};
   localparam logic [MAN_W:0]   M_NAN = {2'b01, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_NORM = 3'd2,
      S_PACK = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state_q;
   logic [OPW-1:0]      a_q, b_q;
   logic [SW-1:0]       sig_a_q, sig_b_q;
   logic [PW-1:0]       p_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [MAN_W-1:0]    frac_q;
   logic [EW-1:0]       e_q;
   logic                grs_q;

   logic                in_ready_q, out_valid_q, zero_q, sp_q, grs_out_q;
   logic [MAN_W:0]      round_m_q, round_mp_q;
   logic [EXP_W:0]      round_e_q, round_ep_q;
   logic [4:0]          exc_q;

   logic [EW-1:0]       e_sum_s, e_d;
   logic [MAN_W-1:0]    frac_d;
   logic                g_s, s_s, grs_d;

   logic [EXP_W-1:0]    ea_s, eb_s;
   logic [MAN_W-1:0]    ma_s, mb_s;
   logic                zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;
   logic                ovf_s, unf_s;
   logic                zf_d, grs_o_d, sp_d;
   logic [MAN_W:0]      rm_d;
   logic [EXP_W:0]      re_d;
   logic [4:0]          exc_d;

   assign e_sum_s = {2'b00, a_q[MAN_W +: EXP_W]} + {2'b00, b_q[MAN_W +: EXP_W]} - EW'(BIAS);

   // Normalize the product: a carry into the top bit shifts the fraction window and bumps E.
   always_comb begin
      frac_d = p_q[PW-3 -: MAN_W];
      g_s    = p_q[PW-3-MAN_W];
      s_s    = |p_q[PW-4-MAN_W:0];
      e_d    = e_sum_s;
      if (p_q[PW-1]) begin
         frac_d = p_q[PW-2 -: MAN_W];
         g_s    = p_q[PW-2-MAN_W];
         s_s    = |p_q[PW-3-MAN_W:0];
         e_d    = e_sum_s + EW'(1);
      end else begin
         frac_d = p_q[PW-3 -: MAN_W];
         g_s    = p_q[PW-3-MAN_W];
         s_s    = |p_q[PW-4-MAN_W:0];
         e_d    = e_sum_s;
      end
      grs_d = g_s & (s_s | frac_d[0]);
   end

   assign ea_s     = a_q[MAN_W +: EXP_W];
   assign eb_s     = b_q[MAN_W +: EXP_W];
   assign ma_s     = a_q[MAN_W-1:0];
   assign mb_s     = b_q[MAN_W-1:0];
   assign zero_a_s = (ea_s == {EXP_W{1'b0}});
   assign zero_b_s = (eb_s == {EXP_W{1'b0}});
   assign inf_a_s  = (ea_s == {EXP_W{1'b1}}) && (ma_s == {MAN_W{1'b0}});
   assign inf_b_s  = (eb_s == {EXP_W{1'b1}}) && (mb_s == {MAN_W{1'b0}});
   assign nan_a_s  = (ea_s == {EXP_W{1'b1}}) && (ma_s != {MAN_W{1'b0}});
   assign nan_b_s  = (eb_s == {EXP_W{1'b1}}) && (mb_s != {MAN_W{1'b0}});
   assign ovf_s    = ($signed(e_q) >= $signed(E_MAX));
   assign unf_s    = ($signed(e_q) <= $signed({EW{1'b0}}));
   assign sp_d     = a_q[OPW-1] ^ b_q[OPW-1];

   // Classify the operands and normalized exponent, highest-priority exception first.
   always_comb begin
      exc_d   = 5'b00000;
      zf_d    = 1'b0;
      rm_d    = {1'b0, frac_q};
      re_d    = e_q[EXP_W:0];
      grs_o_d = grs_q;
      if (nan_a_s || nan_b_s || (zero_a_s && inf_b_s) || (inf_a_s && zero_b_s)) begin
         exc_d   = 5'b10000;
         re_d    = E_SAT;
         rm_d    = M_NAN;
         grs_o_d = 1'b0;
      end else if (inf_a_s || inf_b_s) begin
         exc_d   = 5'b01000;
         re_d    = E_SAT;
         rm_d    = {(MAN_W+1){1'b0}};
         grs_o_d = 1'b0;
      end else if (zero_a_s || zero_b_s) begin
         exc_d   = 5'b00001;
         zf_d    = 1'b1;
         re_d    = {(EXP_W+1){1'b0}};
         rm_d    = {(MAN_W+1){1'b0}};
         grs_o_d = 1'b0;
      end else if (ovf_s) begin
         exc_d   = 5'b00100;
         re_d    = E_SAT;
         rm_d    = {(MAN_W+1){1'b0}};
         grs_o_d = 1'b0;
      end else if (unf_s) begin
         exc_d   = 5'b00010;
         zf_d    = 1'b1;
         re_d    = {(EXP_W+1){1'b0}};
         rm_d    = {(MAN_W+1){1'b0}};
         grs_o_d = 1'b0;
      end else begin
         exc_d   = 5'b00000;
         re_d    = e_q[EXP_W:0];
         rm_d    = {1'b0, frac_q};
         grs_o_d = grs_q;
      end
   end

   // Control FSM with datapath and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= {OPW{1'b0}};
         b_q         <= {OPW{1'b0}};
         sig_a_q     <= {SW{1'b0}};
         sig_b_q     <= {SW{1'b0}};
         p_q         <= {PW{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         frac_q      <= {MAN_W{1'b0}};
         e_q         <= {EW{1'b0}};
         grs_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         sp_q        <= 1'b0;
         grs_out_q   <= 1'b0;
         round_m_q   <= {(MAN_W+1){1'b0}};
         round_mp_q  <= {(MAN_W+1){1'b0}};
         round_e_q   <= {(EXP_W+1){1'b0}};
         round_ep_q  <= {(EXP_W+1){1'b0}};
         exc_q       <= 5'b00000;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  sig_a_q    <= {1'b1, a[MAN_W-1:0]};
                  sig_b_q    <= {1'b1, b[MAN_W-1:0]};
                  p_q        <= {PW{1'b0}};
                  cnt_q      <= {CNT_W{1'b0}};
                  in_ready_q <= 1'b0;
                  state_q    <= S_MUL;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            S_MUL: begin
               if (sig_b_q[cnt_q]) begin
                  p_q <= p_q + (PW'(sig_a_q) << cnt_q);
               end else begin
                  p_q <= p_q;
               end
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MAN_W)) begin
                  state_q <= S_NORM;
               end else begin
                  state_q <= S_MUL;
               end
            end
            S_NORM: begin
               frac_q  <= frac_d;
               e_q     <= e_d;
               grs_q   <= grs_d;
               state_q <= S_PACK;
            end
            S_PACK: begin
               zero_q      <= zf_d;
               sp_q        <= sp_d;
               grs_out_q   <= grs_o_d;
               round_m_q   <= rm_d;
               round_mp_q  <= rm_d + {{MAN_W{1'b0}}, 1'b1};
               round_e_q   <= re_d;
               round_ep_q  <= re_d + {{EXP_W{1'b0}}, 1'b1};
               exc_q       <= exc_d;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  state_q     <= S_DONE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign zeroFlag  = zero_q;
   assign RoundM    = round_m_q;
   assign RoundMP   = round_mp_q;
   assign RoundE    = round_e_q;
   assign RoundEP   = round_ep_q;
   assign Sp        = sp_q;
   assign GRS       = grs_out_q;
   assign InputExc  = exc_q;

endmodule
